// File: rtl/nasti_bram_arb_pkg.sv
// Shared types and helpers for the NASTI BRAM arbiter: round-robin pick,
// one-hot/index conversion and pointer advance, sized for up to MAX_REQ requesters.
package nasti_bram_arb_pkg;

  localparam int MAX_REQ   = 8;
  localparam int IDX_WIDTH = $clog2(MAX_REQ);

  typedef logic [MAX_REQ-1:0]   req_vec_t;
  typedef logic [IDX_WIDTH-1:0] req_idx_t;

  // First valid requester at or after ptr, wrapping at n-1 -> 0; one-hot or zero.
  function automatic req_vec_t rr_pick(input req_vec_t valid, input req_idx_t ptr, input int n);
    req_vec_t grant;
    logic     found;
    int       sum;
    req_idx_t sel;
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      if (k < n) begin
        sum = int'(ptr) + k;
        if (sum >= n) sum = sum - n;
        sel = req_idx_t'(sum);
        if (!found && valid[sel]) begin
          grant[sel] = 1'b1;
          found      = 1'b1;
        end
      end
    end
    return grant;
  endfunction

  // Index of the set bit in a one-hot vector (zero when none set).
  function automatic req_idx_t onehot_to_idx(input req_vec_t oh);
    req_idx_t idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = idx | req_idx_t'(i);
    end
    return idx;
  endfunction

  function automatic req_vec_t idx_to_onehot(input req_idx_t idx);
    return req_vec_t'(1) << idx;
  endfunction

  // (i + 1) mod n
  function automatic req_idx_t next_idx(input req_idx_t i, input int n);
    if (int'(i) >= n - 1) return '0;
    return i + req_idx_t'(1);
  endfunction

endpackage

// File: rtl/nasti_bram_arbiter_rr.sv
// Purely combinational round-robin arbiter: one-hot grant of the first valid
// requester searching upward from ptr.
module rr_arbiter
  import nasti_bram_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]   valid,
  input  logic [IDX_WIDTH-1:0] ptr,
  output logic [NUM_REQ-1:0]   grant
);

  // Pad to the package width, pick, and trim back to NUM_REQ.
  always_comb begin
    grant = NUM_REQ'(rr_pick(req_vec_t'(valid), ptr, NUM_REQ));
  end

endmodule

// File: rtl/nasti_bram_arbiter.sv
// Shares one single-port, one-cycle-latency BRAM between NUM_REQ requesters.
// Round-robin grant, optional grant locking (bounded by LOCK_MAX), and read
// data routed back to the issuing requester with a one-cycle strobe.
module nasti_bram_arbiter
  import nasti_bram_arb_pkg::*;
#(
  parameter int NUM_REQ         = 2,
  parameter int DATA_WIDTH      = 32,
  parameter int BRAM_ADDR_WIDTH = 16,
  parameter int LOCK_MAX        = 16
) (
  input  logic                                 aclk,
  input  logic                                 aresetn,
  input  logic [NUM_REQ-1:0]                   req_valid,
  output logic [NUM_REQ-1:0]                   req_ready,
  input  logic [NUM_REQ-1:0]                   req_lock,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0]      req_we,
  input  logic [NUM_REQ*BRAM_ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]        req_wrdata,
  output logic [NUM_REQ-1:0]                   rsp_valid,
  output logic [DATA_WIDTH-1:0]                rsp_data,
  output logic                                 bram_clk,
  output logic                                 bram_rst,
  output logic                                 bram_en,
  output logic [DATA_WIDTH/8-1:0]              bram_we,
  output logic [BRAM_ADDR_WIDTH-1:0]           bram_addr,
  output logic [DATA_WIDTH-1:0]                bram_wrdata,
  input  logic [DATA_WIDTH-1:0]                bram_rddata
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int CNT_WIDTH  = $clog2(LOCK_MAX + 1);

  logic [IDX_WIDTH-1:0] rr_ptr;
  logic [IDX_WIDTH-1:0] lock_owner;
  logic [IDX_WIDTH-1:0] rsp_owner;
  logic [IDX_WIDTH-1:0] grant_idx;
  logic [CNT_WIDTH-1:0] lock_cnt;
  logic                 locked;
  logic                 rsp_pending;
  logic [NUM_REQ-1:0]   rr_grant;
  logic                 any_accept;
  logic                 lock_req;

  assign bram_clk = aclk;
  assign bram_rst = ~aresetn;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .grant (rr_grant)
  );

  // Grant selection: the lock owner while locked, otherwise round-robin; nothing in reset.
  // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    req_ready = '0;
    if (aresetn) begin
      req_ready = locked ? NUM_REQ'(idx_to_onehot(lock_owner)) : rr_grant;
    end
    any_accept = |(req_valid & req_ready);
    grant_idx  = onehot_to_idx(req_vec_t'(req_ready));
    // req_ready is one-hot, so this is req_lock of the granted (or owning) requester.
    lock_req   = |(req_lock & req_ready);
  end

  // BRAM command mux from the granted requester; strobes only on an accepted access.
  always_comb begin
    bram_en     = any_accept;
    bram_we     = '0;
    bram_addr   = '0;
    bram_wrdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        bram_addr   = req_addr[i*BRAM_ADDR_WIDTH +: BRAM_ADDR_WIDTH];
        bram_wrdata = req_wrdata[i*DATA_WIDTH +: DATA_WIDTH];
        if (req_valid[i]) bram_we = req_we[i*STRB_WIDTH +: STRB_WIDTH];
      end
    end
  end

  // Round-robin pointer and grant lock state.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rr_ptr     <= '0;
      locked     <= 1'b0;
      lock_owner <= '0;
      lock_cnt   <= '0;
    end else if (any_accept) begin
      if (!locked) begin
        rr_ptr <= next_idx(grant_idx, NUM_REQ);
        // With LOCK_MAX of 1 the first grant already exhausts the lock, so never take it.
        if (lock_req && (LOCK_MAX > 1)) begin
          locked     <= 1'b1;
          lock_owner <= grant_idx;
          lock_cnt   <= CNT_WIDTH'(1);
        end
      end else if (lock_req && (lock_cnt != CNT_WIDTH'(LOCK_MAX - 1))) begin
        lock_cnt <= lock_cnt + CNT_WIDTH'(1);
      end else begin
        // Owner released, or this grant reaches LOCK_MAX: hand the BRAM on.
        locked   <= 1'b0;
        lock_cnt <= '0;
        rr_ptr   <= next_idx(grant_idx, NUM_REQ);
      end
    end else if (locked && !lock_req) begin
      // Owner dropped req_lock on an idle cycle.
      locked   <= 1'b0;
      lock_cnt <= '0;
      rr_ptr   <= next_idx(lock_owner, NUM_REQ);
    end
  end

  // Read-response tracking: remember who issued the read accepted this cycle.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rsp_pending <= 1'b0;
      rsp_owner   <= '0;
    end else begin
      rsp_pending <= any_accept && (bram_we == '0);
      if (any_accept) rsp_owner <= grant_idx;
    end
  end

  // Response strobe from registered state; data straight from the BRAM output.
  always_comb begin
    rsp_valid = rsp_pending ? NUM_REQ'(idx_to_onehot(rsp_owner)) : '0;
    rsp_data  = bram_rddata;
  end

endmodule

// File: tb/tb_nasti_bram_arbiter.sv
// Directed, table-driven bench for nasti_bram_arbiter with a write-first
// one-cycle BRAM model.
module tb_nasti_bram_arbiter;

  localparam int NR = 2;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int SW = DW / 8;
  localparam int LM = 4;

  logic             aclk = 1'b0;
  logic             aresetn = 1'b0;
  logic [NR-1:0]    req_valid = '0;
  logic [NR-1:0]    req_ready;
  logic [NR-1:0]    req_lock = '0;
  logic [NR*SW-1:0] req_we = '0;
  logic [NR*AW-1:0] req_addr = '0;
  logic [NR*DW-1:0] req_wrdata = '0;
  logic [NR-1:0]    rsp_valid;
  logic [DW-1:0]    rsp_data;
  logic             bram_clk;
  logic             bram_rst;
  logic             bram_en;
  logic [SW-1:0]    bram_we;
  logic [AW-1:0]    bram_addr;
  logic [DW-1:0]    bram_wrdata;
  logic [DW-1:0]    bram_rddata;

  int errors   = 0;
  int n_checks = 0;

  always #5 aclk = ~aclk;

  nasti_bram_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .BRAM_ADDR_WIDTH(AW), .LOCK_MAX(LM)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_lock(req_lock),
    .req_we(req_we), .req_addr(req_addr), .req_wrdata(req_wrdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .bram_clk(bram_clk), .bram_rst(bram_rst), .bram_en(bram_en),
    .bram_we(bram_we), .bram_addr(bram_addr), .bram_wrdata(bram_wrdata),
    .bram_rddata(bram_rddata)
  );

  // Write-first single-port BRAM model, one-cycle read latency.
  logic [DW-1:0] mem [256];
  logic [DW-1:0] merged;

  always_comb begin
    merged = mem[bram_addr[7:0]];
    for (int b = 0; b < SW; b++) begin
      if (bram_we[b]) merged[b*8 +: 8] = bram_wrdata[b*8 +: 8];
    end
  end

  always @(posedge bram_clk) begin
    if (bram_en) begin
      mem[bram_addr[7:0]] <= merged;
      bram_rddata         <= merged;
    end
  end

  typedef struct {
    logic [1:0]  valid;
    logic [1:0]  lock;
    logic [3:0]  we0;
    logic [15:0] a0;
    logic [31:0] d0;
    logic [3:0]  we1;
    logic [15:0] a1;
    logic [31:0] d1;
    logic [1:0]  ready;
    logic [1:0]  rsp;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[$];
  int   split_at;

  function automatic vec_t mk(input logic [1:0] valid, input logic [1:0] lock,
                              input logic [3:0] we0, input logic [15:0] a0, input logic [31:0] d0,
                              input logic [3:0] we1, input logic [15:0] a1, input logic [31:0] d1,
                              input logic [1:0] ready, input logic [1:0] rsp, input logic [31:0] rdata);
    vec_t v;
    v.valid = valid; v.lock = lock;
    v.we0 = we0; v.a0 = a0; v.d0 = d0;
    v.we1 = we1; v.a1 = a1; v.d1 = d1;
    v.ready = ready; v.rsp = rsp; v.rdata = rdata;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic apply(input vec_t v, input int row);
    logic       exp_en;
    logic [3:0] exp_we;
    @(negedge aclk);
    req_valid  = v.valid;
    req_lock   = v.lock;
    req_we     = {v.we1, v.we0};
    req_addr   = {v.a1, v.a0};
    req_wrdata = {v.d1, v.d0};
    #1;
    exp_en = |(v.ready & v.valid);
    exp_we = v.ready[0] ? v.we0 : v.we1;
    check($sformatf("row%0d req_ready", row), 32'(req_ready), 32'(v.ready));
    check($sformatf("row%0d bram_en", row), 32'(bram_en), 32'(exp_en));
    if (exp_en) begin
      check($sformatf("row%0d bram_we", row), 32'(bram_we), 32'(exp_we));
      check($sformatf("row%0d bram_addr", row), 32'(bram_addr), 32'(v.ready[0] ? v.a0 : v.a1));
      if (exp_we != 4'h0)
        check($sformatf("row%0d bram_wrdata", row), bram_wrdata, v.ready[0] ? v.d0 : v.d1);
    end else begin
      check($sformatf("row%0d bram_we idle", row), 32'(bram_we), 32'h0);
    end
    check($sformatf("row%0d rsp_valid", row), 32'(rsp_valid), 32'(v.rsp));
    if (v.rsp != 2'b00) check($sformatf("row%0d rsp_data", row), rsp_data, v.rdata);
  endtask

  initial begin
    // Preload two words through requesters, then round-robin reads.
    vecs.push_back(mk(2'b01, 2'b00, 4'hF, 16'h10, 32'hAAAA0010, 4'h0, 16'h0,  32'h0,          2'b01, 2'b00, 32'h0));
    vecs.push_back(mk(2'b10, 2'b00, 4'h0, 16'h0,  32'h0,        4'hF, 16'h20, 32'hBBBB0020,   2'b10, 2'b00, 32'h0));
    vecs.push_back(mk(2'b11, 2'b00, 4'h0, 16'h10, 32'h0, 4'h0, 16'h20, 32'h0, 2'b01, 2'b00, 32'h0));
    vecs.push_back(mk(2'b11, 2'b00, 4'h0, 16'h10, 32'h0, 4'h0, 16'h20, 32'h0, 2'b10, 2'b01, 32'hAAAA0010));
    vecs.push_back(mk(2'b11, 2'b00, 4'h0, 16'h10, 32'h0, 4'h0, 16'h20, 32'h0, 2'b01, 2'b10, 32'hBBBB0020));
    vecs.push_back(mk(2'b11, 2'b00, 4'h0, 16'h10, 32'h0, 4'h0, 16'h20, 32'h0, 2'b10, 2'b01, 32'hAAAA0010));
    vecs.push_back(mk(2'b00, 2'b00, 4'h0, 16'h0,  32'h0, 4'h0, 16'h0,  32'h0, 2'b00, 2'b10, 32'hBBBB0020));
    vecs.push_back(mk(2'b00, 2'b00, 4'h0, 16'h0,  32'h0, 4'h0, 16'h0,  32'h0, 2'b00, 2'b00, 32'h0));
    // Lock burst: four locked writes by req0 while req1 waits; lock dropped on the fourth.
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(2'b11, (i < 3) ? 2'b01 : 2'b00, 4'hF, 16'(i), 32'hC0DE0000 | 32'(i),
                        4'h0, 16'h20, 32'h0, 2'b01, 2'b00, 32'h0));
    vecs.push_back(mk(2'b11, 2'b00, 4'h0, 16'h10, 32'h0, 4'h0, 16'h20, 32'h0, 2'b10, 2'b00, 32'h0));
    vecs.push_back(mk(2'b00, 2'b00, 4'h0, 16'h0,  32'h0, 4'h0, 16'h0,  32'h0, 2'b00, 2'b10, 32'hBBBB0020));
    // Readback of the burst.
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(2'b01, 2'b00, 4'h0, 16'(i), 32'h0, 4'h0, 16'h0, 32'h0, 2'b01,
                        (i == 0) ? 2'b00 : 2'b01, 32'hC0DE0000 | 32'(i - 1)));
    vecs.push_back(mk(2'b00, 2'b00, 4'h0, 16'h0, 32'h0, 4'h0, 16'h0, 32'h0, 2'b00, 2'b01, 32'hC0DE0003));
    // Lock timeout: req0 keeps req_lock, broken after LM=4 grants.
    vecs.push_back(mk(2'b01, 2'b01, 4'h0, 16'h10, 32'h0, 4'h0, 16'h20, 32'h0, 2'b01, 2'b00, 32'h0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(2'b11, 2'b01, 4'h0, 16'h10, 32'h0, 4'h0, 16'h20, 32'h0, 2'b01, 2'b01, 32'hAAAA0010));
    vecs.push_back(mk(2'b11, 2'b01, 4'h0, 16'h10, 32'h0, 4'h0, 16'h20, 32'h0, 2'b10, 2'b01, 32'hAAAA0010));
    vecs.push_back(mk(2'b00, 2'b00, 4'h0, 16'h0,  32'h0, 4'h0, 16'h0,  32'h0, 2'b00, 2'b10, 32'hBBBB0020));
    // Idle lock: owner drops req_valid but holds req_lock, then releases on an idle cycle.
    vecs.push_back(mk(2'b01, 2'b01, 4'h0, 16'h10, 32'h0, 4'h0, 16'h20, 32'h0, 2'b01, 2'b00, 32'h0));
    vecs.push_back(mk(2'b10, 2'b01, 4'h0, 16'h10, 32'h0, 4'h0, 16'h20, 32'h0, 2'b01, 2'b01, 32'hAAAA0010));
    vecs.push_back(mk(2'b10, 2'b01, 4'h0, 16'h10, 32'h0, 4'h0, 16'h20, 32'h0, 2'b01, 2'b00, 32'h0));
    vecs.push_back(mk(2'b10, 2'b01, 4'h0, 16'h10, 32'h0, 4'h0, 16'h20, 32'h0, 2'b01, 2'b00, 32'h0));
    vecs.push_back(mk(2'b10, 2'b00, 4'h0, 16'h10, 32'h0, 4'h0, 16'h20, 32'h0, 2'b01, 2'b00, 32'h0));
    vecs.push_back(mk(2'b10, 2'b00, 4'h0, 16'h10, 32'h0, 4'h0, 16'h20, 32'h0, 2'b10, 2'b00, 32'h0));
    vecs.push_back(mk(2'b00, 2'b00, 4'h0, 16'h0,  32'h0, 4'h0, 16'h0,  32'h0, 2'b00, 2'b10, 32'hBBBB0020));
    split_at = vecs.size();
    // After mid-read reset: partial-strobe write by req1, then read of the same word by req0.
    vecs.push_back(mk(2'b10, 2'b00, 4'h0, 16'h0,  32'h0, 4'b0011, 16'h20, 32'hDEADBEEF, 2'b10, 2'b00, 32'h0));
    vecs.push_back(mk(2'b01, 2'b00, 4'h0, 16'h20, 32'h0, 4'h0,    16'h0,  32'h0,        2'b01, 2'b00, 32'h0));
    vecs.push_back(mk(2'b00, 2'b00, 4'h0, 16'h0,  32'h0, 4'h0,    16'h0,  32'h0,        2'b00, 2'b01, 32'hBBBBBEEF));

    // Reset state with both requesters asking.
    aresetn   = 1'b0;
    req_valid = 2'b11;
    repeat (2) @(negedge aclk);
    #1;
    check("reset req_ready", 32'(req_ready), 32'h0);
    check("reset rsp_valid", 32'(rsp_valid), 32'h0);
    check("reset bram_en", 32'(bram_en), 32'h0);
    check("reset bram_we", 32'(bram_we), 32'h0);
    check("reset bram_rst", 32'(bram_rst), 32'h1);
    req_valid = 2'b00;
    @(negedge aclk);
    aresetn = 1'b1;
    #1;
    check("run bram_rst", 32'(bram_rst), 32'h0);

    for (int r = 0; r < split_at; r++) apply(vecs[r], r);

    // Mid-read reset: locked read accepted, reset right after the edge.
    @(negedge aclk);
    req_valid = 2'b01;
    req_lock  = 2'b01;
    req_we    = '0;
    req_addr  = {16'h20, 16'h10};
    #1;
    check("midrst accept", 32'(req_ready), 32'h1);
    @(posedge aclk);
    #1;
    aresetn   = 1'b0;
    req_valid = 2'b00;
    req_lock  = 2'b00;
    #1;
    check("midrst rsp_valid in reset", 32'(rsp_valid), 32'h0);
    @(negedge aclk);
    aresetn = 1'b1;
    #1;
    check("midrst rsp_valid after reset", 32'(rsp_valid), 32'h0);

    for (int r = split_at; r < vecs.size(); r++) apply(vecs[r], r);

    $display("Result: errors=%0d of %0d checks", errors, n_checks);
    $finish;
  end

endmodule

// File: doc/nasti_bram_arbiter.md
Name: nasti_bram_arbiter

Overview:
- Shares one single-port BRAM between NUM_REQ native requesters using round-robin arbitration, with optional grant locking for bursts and read-modify-write sequences.
- Sits between several BRAM masters and one BRAM macro. Typical masters are nasti_bram_ctrl instances, a debug or loader port, and DMA.
- BRAM read latency is fixed at one cycle. Read data is returned to the requester that issued the read, tagged by a response-valid strobe.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- DATA_WIDTH, 32, BRAM data width in bits (multiple of 8).
- BRAM_ADDR_WIDTH, 16, BRAM word/byte address width, passed through unchanged.
- LOCK_MAX, 16, maximum consecutive locked grants to one owner before the lock is forcibly broken (≥1).

Ports:
- aclk  in  1  clock; also drives bram_clk.
- aresetn  in  1  reset, asynchronous assert, active-low.
- req_valid  in  NUM_REQ  per-requester access request.
- req_ready  out  NUM_REQ  one-hot grant; an access is accepted when req_valid[i] & req_ready[i].
- req_lock  in  NUM_REQ  requester wants to keep the grant after this access.
- req_we  in  NUM_REQ*DATA_WIDTH/8  byte write strobes (all zero = read).
- req_addr  in  NUM_REQ*BRAM_ADDR_WIDTH  addresses.
- req_wrdata  in  NUM_REQ*DATA_WIDTH  write data.
- rsp_valid  out  NUM_REQ  one-cycle read-data strobe for requester i.
- rsp_data  out  DATA_WIDTH  read data, shared by all requesters, meaningful only with rsp_valid.
- bram_clk  out  1  equals aclk.
- bram_rst  out  1  equals !aresetn.
- bram_en, bram_we, bram_addr, bram_wrdata  out  1 / DATA_WIDTH/8 / BRAM_ADDR_WIDTH / DATA_WIDTH  BRAM command.
- bram_rddata  in  DATA_WIDTH  BRAM read data.

Behaviour:
- Reset values (asynchronous) and state:
  - rr_ptr=0, locked=0, lock_owner=0, lock_cnt=0, rsp_pending=0, rsp_owner=0.
  - Outputs: rsp_valid=0, bram_en=0, bram_we=0, req_ready=0.
- Grant is combinational from registered state plus the current req_valid:
  - If locked: req_ready = onehot(lock_owner); all other requesters are blocked, even when the owner drops req_valid.
  - Else: req_ready = first requester with req_valid set, searching from rr_ptr upward with wrap NUM_REQ-1 -> 0. req_ready=0 when no requester is valid.
- BRAM command:
  - bram_en = any accepted access.
  - bram_we/addr/wrdata are muxed from the granted requester.
  - bram_we=0 when not accepted; addr/wrdata are don't-care.
- On each accepted access by requester g:
  - Unlocked case: rr_ptr <= (g+1) mod NUM_REQ.
  - Lock start: if req_lock[g] and not locked, then locked<=1, lock_owner<=g, lock_cnt<=1.
  - Lock continue: if locked and req_lock[g], then lock_cnt increments. When lock_cnt reaches LOCK_MAX, the lock is forcibly released: locked<=0, lock_cnt<=0, rr_ptr<=(g+1).
  - Lock release: if locked and !req_lock[g], then locked<=0, lock_cnt<=0, rr_ptr<=(g+1).
  - While locked, an owner cycle with no accepted access leaves lock state unchanged; the owner may deassert req_lock on an idle cycle to release.
- Read response:
  - An accepted read (req_we==0) sets rsp_pending<=1 and rsp_owner<=g.
  - The next cycle: rsp_valid = onehot(rsp_owner) when rsp_pending, and rsp_data = bram_rddata.
  - There is no response backpressure; requesters must capture or register the data.
- Reads are pipelined, with one access per cycle sustained.
- Back-to-back reads from different requesters return in order, each on the cycle after its acceptance.
- Writes produce no response.
- A write and a read to the same address in consecutive cycles: the read observes the written data, because the BRAM writes first.
- Reset mid-operation: a pending response is discarded (rsp_valid=0) and the lock is dropped.

Decomposition:
- Package nasti_bram_arb_pkg:
  - function rr_pick(valid, ptr) returning a onehot vector.
  - onehot-to-index function.
  - localparams for STRB_WIDTH and the log2 index width.
- One sub-module is natural: rr_arbiter (valid in, ptr in, onehot grant out; purely combinational, reusable).
- The main block holds the lock, pointer and response registers.

Test Plan:
- Reset: assert aresetn=0 while req_valid=2'b11 -> req_ready, rsp_valid, bram_en and bram_we are all 0.
- Round-robin fairness: both requesters issue continuous reads, req0 to 0x10 and req1 to 0x20, starting from reset.
  - Grants alternate 0,1,0,1.
  - rsp_valid alternates 01,10 one cycle after each grant, with rsp_data matching preloaded words 0xAAAA0010 and 0xBBBB0020.
- Lock burst: req0 holds req_lock for 4 writes at 0x00..0x03 while req1 is valid.
  - req1 stays blocked for 4 cycles and is granted on cycle 5.
  - Readback returns the 4 written words.
- Lock timeout: LOCK_MAX=4, req0 holds req_lock for 10 accesses -> after 4 grants the lock breaks and req1 gets the next grant.
- Idle lock: req0 locks, then drops req_valid for 3 cycles while keeping req_lock -> req1 is not granted. req0 then deasserts req_lock -> req1 is granted the next cycle.
- Mid-read reset plus write-then-read:
  - Reset asserted the cycle after a read accept -> no rsp_valid is produced.
  - After reset: req1 writes 0xDEADBEEF with strobe 4'b0011, then req0 reads the same address -> low half is 0xBEEF and the upper bytes are unchanged.
